serial_deser_32: RTL
====================

Name: serial_deser_32

Overview:
- Serial-in/parallel-out receiver: the receiving end of a serial stream produced by the team's 32-bit universal shift register in shift-left or shift-right mode.
- Assembles WIDTH serial bits into one word, MSB-first or LSB-first.
- Holds the word in an output register with a valid/ready handshake, so the next word can assemble while the consumer stalls.
- Flags overruns.

Parameters:
WIDTH, 32, word length in bits (≥2); bit counter width is clog2(WIDTH+1)

Ports:
clk  input  1  rising-edge clock; the only clock
clear  input  1  asynchronous, active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on this edge when high
msb_first  input  1  1 = first bit is word bit WIDTH-1 (shift-left order); 0 = first bit is bit 0 (shift-right order)
abort  input  1  synchronous discard of the partially assembled word
dout  output  WIDTH  assembled word (holding register)
dout_valid  output  1  holding register full
dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1
busy  output  1  partial word in progress (bit count ≠ 0)
bit_cnt  output  clog2(WIDTH+1)  bits received in the current word
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (clear=1, asynchronous): shift register=0, dout=0, dout_valid=0, bit_cnt=0, busy=0, overrun=0, state=IDLE, latched order=MSB-first.
- FSM states: IDLE (no bits held), RECV (1..WIDTH-1 bits held), PAR (awaiting the parity bit; exists only with PARITY_EN).
- IDLE, sin_valid=1:
  - Latch msb_first as the word order; it is ignored for the rest of the word.
  - Shift the first bit in, bit_cnt=1, go to RECV.
- Shift rules:
  - MSB-first: sh <= {sh[WIDTH-2:0], sin}.
  - LSB-first: sh <= {sin, sh[WIDTH-1:1]}.
  - After WIDTH bits, word bit k equals the bit sent for position k in either order.
- RECV, sin_valid=1:
  - bit_cnt increments.
  - If this is bit WIDTH: the word is complete on this edge; bit_cnt returns to 0; next state is IDLE (or PAR with PARITY_EN).
- Holding-register load (without PARITY_EN): on the completing edge.
  - dout_valid becomes 1 and dout shows the word in the cycle after the last bit is sampled (1-cycle latency).
- Load conditions on the completing edge:
  - Holding empty → load.
  - Holding full and drained on the same edge (dout_valid & dout_ready) → load; dout_valid stays 1.
  - Holding full and not drained → new word dropped, dout unchanged, overrun<=1.
- Drain: dout_valid & dout_ready with no simultaneous load → dout_valid<=0. dout holds its last value.
- sin_valid=0: no state change; gaps of any length are allowed mid-word.
- abort=1:
  - Next state IDLE, bit_cnt=0, shift register cleared.
  - Takes priority over sin_valid on the same edge; a word completing on that edge is discarded.
  - Holding register and handshake are unaffected.
- overrun:
  - Set by a drop; cleared only by ovr_clr or clear.
  - Set and ovr_clr on the same edge → set wins.
- busy = (bit_cnt ≠ 0) or state=PAR.
- clear asserted mid-word or mid-handshake → immediate return to reset values; partial data and held word are lost.

Optional Feature:
PARITY_EN
- Defined:
  - After WIDTH data bits, the FSM enters PAR and consumes one more sin_valid bit as even parity (XOR of data bits and parity bit must be 0).
  - The holding-register load (same rules as above) occurs on the parity edge, not on the bit-WIDTH edge.
  - Output port par_err (1 bit) loads with the result alongside dout: 1 = mismatch, 0 = match. It holds with dout and resets to 0.
  - A dropped word does not update par_err.
- Undefined: no PAR state, no par_err port; the word loads on the WIDTH-th bit.

Test Plan:
- MSB-first, 32 contiguous bits of 0xA5C3_0F81, dout_ready=1 → dout=0xA5C30F81 and dout_valid=1 the cycle after bit 32; bit_cnt 1..31 then 0; busy low afterwards.
- LSB-first, same bits sent bit 0 first, with sin_valid toggled 1/0 each cycle → dout=0xA5C30F81 after 63 cycles; no extra bits captured during gaps.
- dout_ready=0; send 0x00000001 then 0xFFFFFFFF → dout stays 0x00000001, overrun=1. Pulse ovr_clr → overrun=0. Raise dout_ready on the edge a third word 0x12345678 completes → dout=0x12345678 and dout_valid remains 1.
- Send 17 bits, assert abort for one cycle, then send a full word 0xDEADBEEF → dout=0xDEADBEEF, no residue from the aborted bits.
- Assert clear asynchronously (mid-cycle) after 10 bits with a word held → all outputs 0 immediately; next full word assembles correctly.
- PARITY_EN: send 0x00000003 with parity 0 → par_err=0. Send 0x00000007 with parity 0 → par_err=1. dout_valid rises one cycle after the parity bit each time.

Source files
------------

// File: rtl/serial_deser_32.sv
// Serial-in/parallel-out receiver with a valid/ready holding register.
// Optional even-parity trailer bit enabled by defining PARITY_EN.
module serial_deser_32 #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             abort,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
`ifdef PARITY_EN
    output logic             par_err,
`endif
    input  logic             ovr_clr
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_PAR
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV
    } state_t;
`endif

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sh;
    logic [CW-1:0]      r_cnt;
    logic               r_msb;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dv;
    logic               r_ovr;
`ifdef PARITY_EN
    logic               r_par_err;
    logic               w_perr;
`endif

    logic               w_order;
    logic [WIDTH-1:0]   w_shift;
    logic               w_take;
    logic               w_done;
    logic [WIDTH-1:0]   w_word;
    logic               w_drain;
    logic               w_load;
    logic               w_drop;

    // Word order is taken live on the first bit, then from the latch.
    always_comb begin
        w_order = (r_state == S_IDLE) ? msb_first : r_msb;
        if (w_order) begin
            w_shift = {r_sh[WIDTH-2:0], sin};
        end else begin
            w_shift = {sin, r_sh[WIDTH-1:1]};
        end
        w_take = sin_valid & ~abort;
`ifdef PARITY_EN
        w_done = w_take & (r_state == S_PAR);
        w_word = r_sh;
        w_perr = ^{r_sh, sin};
`else
        w_done = w_take & (r_state == S_RECV) & (r_cnt == LAST);
        w_word = w_shift;
`endif
        w_drain = r_dv & dout_ready;
        w_load  = w_done & (~r_dv | dout_ready);
        w_drop  = w_done & r_dv & ~dout_ready;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_msb   <= 1'b1;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            if (abort) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_sh    <= '0;
            end else if (sin_valid) begin
                unique case (r_state)
                    S_IDLE: begin
                        r_msb   <= msb_first;
                        r_sh    <= w_shift;
                        r_cnt   <= CW'(1);
                        r_state <= S_RECV;
                    end
                    S_RECV: begin
                        r_sh <= w_shift;
                        if (r_cnt == LAST) begin
                            r_cnt <= '0;
`ifdef PARITY_EN
                            r_state <= S_PAR;
`else
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
`ifdef PARITY_EN
                    S_PAR: begin
                        r_state <= S_IDLE;
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end

            // A load on the draining edge keeps valid high.
            if (w_load) begin
                r_dout <= w_word;
                r_dv   <= 1'b1;
`ifdef PARITY_EN
                r_par_err <= w_perr;
`endif
            end else if (w_drain) begin
                r_dv <= 1'b0;
            end

            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dv;
    assign bit_cnt    = r_cnt;
    assign overrun    = r_ovr;
`ifdef PARITY_EN
    assign par_err    = r_par_err;
    assign busy       = (r_cnt != '0) | (r_state == S_PAR);
`else
    assign busy       = (r_cnt != '0);
`endif

endmodule
